// File: rtl/ooo_pkg.sv
// Shared encodings for the ROB retirement path: architectural register codes,
// payload field offsets and the commit FSM state type.
package ooo_pkg;

    localparam logic [2:0] ARCH_NONE = 3'd0;
    localparam logic [2:0] ARCH_A    = 3'd1;
    localparam logic [2:0] ARCH_X    = 3'd2;
    localparam logic [2:0] ARCH_Y    = 3'd3;
    localparam logic [2:0] ARCH_SP   = 3'd4;
    localparam logic [2:0] ARCH_P    = 3'd5;

    localparam int ARCH_W   = 3;
    localparam int NUM_ARCH = 5;

    // Payload is {exc, arch_dst, phys_dst}; phys_dst sits at bit 0.
    function automatic int arch_lsb(input int phys_w);
        return phys_w;
    endfunction

    function automatic int exc_bit(input int phys_w);
        return phys_w + ARCH_W;
    endfunction

    typedef enum logic [1:0] {RUN, FLUSH, WAIT} commit_state_t;

endpackage

// File: rtl/commit_compact.sv
// Packs valid-masked tags toward the LSB without gaps and reports how many
// are valid. Purely combinational.
module commit_compact #(
    parameter int N  = 3,
    parameter int TW = 6
) (
    input  logic [N*TW-1:0]     tags_i,
    input  logic [N-1:0]        valid_i,
    output logic [N*TW-1:0]     packed_o,
    output logic [$clog2(N):0]  count_o
);

    always_comb begin
        packed_o = '0;
        count_o  = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i]) begin
                packed_o[count_o*TW +: TW] = tags_i[i*TW +: TW];
                count_o = count_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement: updates the retirement RAT, frees displaced tags and
// flushes on an excepting entry. Stats counters exist only with ROB_COMMIT_STATS_EN.
//   state | meaning
//   RUN   | accepting up to PUSH_WIDTH entries per cycle
//   FLUSH | one-cycle flush pulse, RAT exported on rat_out
//   WAIT  | holding off the ROB until flush_done
module rob_commit
    import ooo_pkg::*;
#(
    parameter int PUSH_WIDTH = 3,
    parameter int PHYS_WIDTH = 6,
    parameter int PAYLOAD_W  = PHYS_WIDTH + 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PAYLOAD_W*PUSH_WIDTH-1:0]  rob_dout,
    input  logic [$clog2(PUSH_WIDTH):0]      rob_valid_ct,
    output logic [$clog2(PUSH_WIDTH):0]      rob_ready_ct,
    output logic [PHYS_WIDTH*PUSH_WIDTH-1:0] free_tags,
    output logic [$clog2(PUSH_WIDTH):0]      free_valid_ct,
    output logic [$clog2(PUSH_WIDTH):0]      commit_ct,
    output logic                             flush,
    input  logic                             flush_done,
    output logic [5*PHYS_WIDTH-1:0]          rat_out,
    output logic [31:0]                      retired_cnt,
    output logic [15:0]                      flush_cnt
);

    localparam int CW       = $clog2(PUSH_WIDTH) + 1;
    localparam int ARCH_LSB = arch_lsb(PHYS_WIDTH);
    localparam int EXC_BIT  = exc_bit(PHYS_WIDTH);

    commit_state_t state_q, state_d;

    logic [PHYS_WIDTH-1:0] rat_q [NUM_ARCH];
    logic [PHYS_WIDTH-1:0] rat_d [NUM_ARCH];

    logic                  exc_s  [PUSH_WIDTH];
    logic [ARCH_W-1:0]     arch_s [PUSH_WIDTH];
    logic [PHYS_WIDTH-1:0] phys_s [PUSH_WIDTH];

    logic [CW-1:0] valid_clamped, take_ct;
    logic [CW-1:0] commit_d, commit_q;
    logic [CW-1:0] free_ct_d, free_ct_q;
    logic [PHYS_WIDTH*PUSH_WIDTH-1:0] freed_raw, free_tags_d, free_tags_q;
    logic [PUSH_WIDTH-1:0] freed_mask;
    logic go_flush;

    for (genvar g = 0; g < PUSH_WIDTH; g++) begin : g_slot
        assign exc_s[g]  = rob_dout[g*PAYLOAD_W + EXC_BIT];
        assign arch_s[g] = rob_dout[g*PAYLOAD_W + ARCH_LSB +: ARCH_W];
        assign phys_s[g] = rob_dout[g*PAYLOAD_W +: PHYS_WIDTH];
    end

    assign rob_ready_ct  = (state_q == RUN) ? CW'(PUSH_WIDTH) : '0;
    assign valid_clamped = (rob_valid_ct > CW'(PUSH_WIDTH)) ? CW'(PUSH_WIDTH) : rob_valid_ct;
    assign take_ct       = (valid_clamped < rob_ready_ct) ? valid_clamped : rob_ready_ct;

    // Slots walk in age order so a later write to the same arch reg frees the earlier one.
    always_comb begin
        rat_d      = rat_q;
        freed_raw  = '0;
        freed_mask = '0;
        commit_d   = '0;
        go_flush   = 1'b0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if ((CW'(i) < take_ct) && !go_flush) begin
                if (exc_s[i]) begin
                    go_flush = 1'b1;
                end else begin
                    commit_d = commit_d + 1'b1;
                    if ((arch_s[i] >= ARCH_A) && (arch_s[i] <= ARCH_P)) begin
                        freed_raw[i*PHYS_WIDTH +: PHYS_WIDTH] = rat_d[arch_s[i] - ARCH_A];
                        freed_mask[i]                         = 1'b1;
                        rat_d[arch_s[i] - ARCH_A]             = phys_s[i];
                    end
                end
            end
        end
    end

    commit_compact #(
        .N  (PUSH_WIDTH),
        .TW (PHYS_WIDTH)
    ) u_compact (
        .tags_i   (freed_raw),
        .valid_i  (freed_mask),
        .packed_o (free_tags_d),
        .count_o  (free_ct_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (go_flush) state_d = FLUSH;
            FLUSH:   state_d = WAIT;
            WAIT:    if (flush_done) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            for (int k = 0; k < NUM_ARCH; k++) rat_q[k] <= PHYS_WIDTH'(k);
            free_tags_q <= '0;
            free_ct_q   <= '0;
            commit_q    <= '0;
        end else begin
            state_q     <= state_d;
            rat_q       <= rat_d;
            free_tags_q <= free_tags_d;
            free_ct_q   <= free_ct_d;
            commit_q    <= commit_d;
        end
    end

    assign free_tags     = free_tags_q;
    assign free_valid_ct = free_ct_q;
    assign commit_ct     = commit_q;
    assign flush         = (state_q == FLUSH);

    for (genvar k = 0; k < NUM_ARCH; k++) begin : g_rat
        assign rat_out[k*PHYS_WIDTH +: PHYS_WIDTH] = rat_q[k];
    end

`ifdef ROB_COMMIT_STATS_EN
    logic [31:0] retired_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            retired_q <= retired_q + 32'(commit_q);
            if (flush) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign flush_cnt   = flush_cnt_q;
`else
    assign retired_cnt = '0;
    assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed plus random bench for rob_commit against a rename-map model built
// from plain arrays and queues.
`timescale 1ns/1ps
module tb_rob_commit;

    localparam int PW = 3;
    localparam int TW = 6;
    localparam int LW = TW + 4;
    localparam int CW = $clog2(PW) + 1;
`ifdef ROB_COMMIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [LW*PW-1:0] rob_dout = '0;
    logic [CW-1:0]   rob_valid_ct = '0;
    logic [CW-1:0]   rob_ready_ct;
    logic [TW*PW-1:0] free_tags;
    logic [CW-1:0]   free_valid_ct;
    logic [CW-1:0]   commit_ct;
    logic            flush;
    logic            flush_done = 1'b0;
    logic [5*TW-1:0] rat_out;
    logic [31:0]     retired_cnt;
    logic [15:0]     flush_cnt;

    rob_commit #(.PUSH_WIDTH(PW), .PHYS_WIDTH(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rob_dout      (rob_dout),
        .rob_valid_ct  (rob_valid_ct),
        .rob_ready_ct  (rob_ready_ct),
        .free_tags     (free_tags),
        .free_valid_ct (free_valid_ct),
        .commit_ct     (commit_ct),
        .flush         (flush),
        .flush_done    (flush_done),
        .rat_out       (rat_out),
        .retired_cnt   (retired_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: architectural map, a phase flag (0 accepting, 1 flushing, 2 waiting), stats.
    int          m_map [5];
    int          m_phase;
    longint      exp_ret;
    int          exp_flsh;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] slot(input int exc, input int arch, input int phys);
        logic [LW-1:0] s;
        s = {exc[0], arch[2:0], phys[TW-1:0]};
        return s;
    endfunction

    function automatic logic [LW*PW-1:0] grp(input logic [LW-1:0] s0, input logic [LW-1:0] s1,
                                             input logic [LW-1:0] s2);
        return {s2, s1, s0};
    endfunction

    function automatic logic [5*TW-1:0] model_rat();
        logic [5*TW-1:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r[k*TW +: TW] = TW'(m_map[k]);
        return r;
    endfunction

    task automatic check_rat(input string tag);
        check(tag, rat_out, model_rat());
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_retired"}, retired_cnt, STATS ? (exp_ret & 64'hFFFF_FFFF) : 64'd0);
        check({tag, "_flushes"}, flush_cnt, STATS ? (exp_flsh & 16'hFFFF) : 0);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        rob_dout     = '0;
        rob_valid_ct = '0;
        flush_done   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_phase  = 0;
        for (int k = 0; k < 5; k++) m_map[k] = k;
        exp_ret  = 0;
        exp_flsh = 0;
        check("rst_flush", flush, 0);
        check("rst_commit", commit_ct, 0);
        check("rst_free_ct", free_valid_ct, 0);
        check("rst_free_tags", free_tags, 0);
        check("rst_ready", rob_ready_ct, PW);
        check_rat("rst_rat");
        check_stats("rst");
    endtask

    task automatic do_cycle(input logic [LW*PW-1:0] d, input int vct, input logic fd);
        int n;
        int commit;
        int arch;
        logic go;
        logic [LW-1:0] s;
        int freed[$];
        logic [TW*PW-1:0] exp_ft;

        check("ready", rob_ready_ct, (m_phase == 0) ? PW : 0);
        rob_dout     = d;
        rob_valid_ct = CW'(vct);
        flush_done   = fd;

        n      = (m_phase == 0) ? ((vct > PW) ? PW : vct) : 0;
        commit = 0;
        go     = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = d[i*LW +: LW];
            if (s[LW-1]) begin
                go = 1'b1;
                break;
            end
            commit++;
            arch = int'(s[TW +: 3]);
            if (arch >= 1 && arch <= 5) begin
                freed.push_back(m_map[arch-1]);
                m_map[arch-1] = int'(s[TW-1:0]);
            end
        end
        case (m_phase)
            0:       if (go) m_phase = 1;
            1:       m_phase = 2;
            default: if (fd) m_phase = 0;
        endcase
        exp_ret += commit;
        if (m_phase == 1) exp_flsh++;

        @(posedge clk);
        #1;
        exp_ft = '0;
        foreach (freed[k]) exp_ft[k*TW +: TW] = TW'(freed[k]);
        check("commit_ct", commit_ct, commit);
        check("free_valid_ct", free_valid_ct, freed.size());
        check("free_tags", free_tags, exp_ft);
        check("flush", flush, (m_phase == 1) ? 1 : 0);
        check_rat("rat");
    endtask

    task automatic idle(input logic fd);
        do_cycle('0, 0, fd);
    endtask

    initial begin
        logic [LW*PW-1:0] rd;
        logic [LW-1:0]    rs [PW];

        // 1: two renames plus a no-destination entry
        do_reset();
        do_cycle(grp(slot(0, 1, 10), slot(0, 2, 11), slot(0, 0, 5)), 3, 1'b0);
        check("t1_free_lit", free_tags, {6'd0, 6'd1, 6'd0});
        check("t1_rat_a", rat_out[0 +: TW], 10);
        check("t1_rat_x", rat_out[TW +: TW], 11);
        idle(1'b0);

        // 2: same arch three times in one group
        do_reset();
        do_cycle(grp(slot(0, 1, 20), slot(0, 1, 21), slot(0, 1, 22)), 3, 1'b0);
        check("t2_free_lit", free_tags, {6'd21, 6'd20, 6'd0});
        check("t2_rat_a", rat_out[0 +: TW], 22);

        // 3: exception in slot 1, flush_done ignored during FLUSH, held in WAIT
        do_reset();
        do_cycle(grp(slot(0, 3, 30), slot(1, 0, 0), slot(0, 2, 31)), 3, 1'b0);
        check("t3_rat_x", rat_out[TW +: TW], 1);
        check("t3_free_lit", free_tags, 18'd2);
        do_cycle(grp(slot(0, 1, 40), slot(0, 2, 41), slot(0, 3, 42)), 3, 1'b1);
        for (int w = 0; w < 3; w++)
            do_cycle(grp(slot(0, 1, 40), slot(0, 2, 41), slot(0, 3, 42)), 3, 1'b0);
        idle(1'b1);
        do_cycle(grp(slot(0, 4, 50), slot(0, 5, 51), slot(0, 0, 52)), 3, 1'b0);
        idle(1'b0);
        check_stats("t3");

        // 4: partial group then nothing; clamp an oversize valid count
        do_cycle(grp(slot(0, 4, 40), slot(0, 5, 41), slot(0, 1, 42)), 2, 1'b0);
        do_cycle(grp(slot(0, 4, 43), slot(0, 5, 44), slot(0, 1, 45)), 0, 1'b0);
        do_cycle(grp(slot(0, 2, 46), slot(0, 3, 47), slot(0, 2, 48)), 7, 1'b0);

        // 5: reset while waiting for the front end
        do_cycle(grp(slot(1, 1, 60), slot(0, 2, 61), slot(0, 3, 62)), 3, 1'b0);
        idle(1'b0);
        idle(1'b0);
        do_reset();

        // 6: four full groups then an exception
        for (int g = 0; g < 4; g++)
            do_cycle(grp(slot(0, 1 + g, 10 + g), slot(0, 0, 0), slot(0, 5 - g, 20 + g)), 3, 1'b0);
        do_cycle(grp(slot(1, 1, 33), slot(0, 2, 34), slot(0, 3, 35)), 3, 1'b0);
        idle(1'b0);
        check_stats("t6");
        check("t6_ret_lit", retired_cnt, STATS ? 12 : 0);
        check("t6_flush_lit", flush_cnt, STATS ? 1 : 0);
        idle(1'b1);

        // random traffic
        do_reset();
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < PW; i++)
                rs[i] = slot(($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 7),
                             $urandom_range(0, 63));
            rd = grp(rs[0], rs[1], rs[2]);
            do_cycle(rd, $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            if (it % 50 == 49) begin
                idle(1'b0);
                check_stats("rand");
            end
            if (it == 200) do_reset();
        end
        idle(1'b0);
        check_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
